// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: states, opcodes,
// ALU/mux select constants and condition codes.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_WD  = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_4   = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;

  localparam logic ADR_PC  = 1'b0;
  localparam logic ADR_RES = 1'b1;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against stored {N,Z,C,V}; code 1111 never executes.
module cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  always_comb begin
    {n, z, c, v} = flags;
    ge = (n == v);
    CondEx = 1'b0;
    case (cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle sequencer: Moore FSM driving datapath enables/selects, plus the
// NZCV flag register and condition gating of every write strobe.
module mc_control_fsm
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:12] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [1:0] op;
  logic       imm_i, s_l, cond_ex, no_write, rd_pc, wb_en, cv_cmd;
  logic [3:0] cmd;
  logic [1:0] alu_cmd;
  logic       pc_w, reg_w, ir_w, mem_w;

  assign op    = Instr[27:26];
  assign imm_i = Instr[25];
  assign cmd   = Instr[24:21];
  assign s_l   = Instr[20];
  assign rd_pc = (Instr[15:12] == 4'hF);

  cond_check u_cond (
    .cond   (Instr[31:28]),
    .flags  (flags_q),
    .CondEx (cond_ex)
  );

  // Unsupported cmds run as ADD and, like CMP, never write back.
  always_comb begin
    alu_cmd  = ALU_ADD;
    no_write = 1'b0;
    cv_cmd   = 1'b0;
    if (op == OP_DP) begin
      case (cmd)
        CMD_ADD: begin alu_cmd = ALU_ADD; cv_cmd = 1'b1; end
        CMD_SUB: begin alu_cmd = ALU_SUB; cv_cmd = 1'b1; end
        CMD_AND: alu_cmd = ALU_AND;
        CMD_ORR: alu_cmd = ALU_ORR;
        CMD_CMP: begin alu_cmd = ALU_SUB; cv_cmd = 1'b1; no_write = 1'b1; end
        default: begin alu_cmd = ALU_ADD; no_write = 1'b1; end
      endcase
    end
  end

  assign wb_en = cond_ex & ~no_write;

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = ADR_PC;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    RegSrc     = 2'b00;
    ImmSrc     = 2'b00;
    if (state_q != S_FETCH) begin
      RegSrc = {(op == OP_MEM) & ~s_l, op == OP_B};
      ImmSrc = op;
    end
    case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = imm_i ? S_EXECI : S_EXECR;
          OP_B:    state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = s_l ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = ADR_RES;
        state_d = S_MEMWB;
      end
      S_MEMWR: begin
        AdrSrc  = ADR_RES;
        mem_w   = cond_ex;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_WD;
        ALUControl = alu_cmd;
        state_d    = S_ALUWB;
        // Flags sampled from this cycle's ALU; CondEx still sees the old ones.
        if (cond_ex && s_l) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (cv_cmd) flags_d[1:0] = ALUFlags[1:0];
        end
      end
      S_MEMWB, S_ALUWB: begin
        ResultSrc = (state_q == S_MEMWB) ? RES_DATA : RES_ALUOUT;
        pc_w      = rd_pc & wb_en;
        reg_w     = ~rd_pc & wb_en;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        pc_w      = cond_ex;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by reset directly so none can pulse during an abort.
  assign PCWrite  = pc_w  & reset;
  assign RegWrite = reg_w & reset;
  assign IRWrite  = ir_w  & reset;
  assign MemWrite = mem_w & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle output vectors for each instruction class.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:12] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        PCWrite, RegWrite, IRWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl;
  logic [15:0] obs, exp_v;
  int          checks = 0, failures = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, RegWrite, IRWrite, MemWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl};

  // Packs an expected output set in the same order as obs.
  function automatic logic [15:0] mk(input logic pc, rw, ir, mw, adr, asa,
                                     input logic [1:0] asb, rs, rsrc, imm, alu);
    return {pc, rw, ir, mw, adr, asa, asb, rs, rsrc, imm, alu};
  endfunction

  localparam logic [15:0] E_FETCH = 16'b1010_0_1_10_10_00_00_00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] word);
    Instr = word[31:12];
  endtask

  task automatic test_reset();
    load(32'hE2821005);
    #2;
    checks++;
    exp_v = mk(0,0,0,0, 0,1,2'd2,2'd2, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_add_imm();
    load(32'hE2821005);
    checks++;
    if (obs !== E_FETCH) begin failures++; $display("FAIL addi_fetch got=%h exp=%h", obs, E_FETCH); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,1,2'd2,2'd2, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL addi_decode got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd1,2'd0, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL addi_execi got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,1,0,0, 0,0,2'd0,2'd0, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL addi_aluwb got=%h exp=%h", obs, exp_v); end
    tick();
  endtask

  task automatic test_cmp_beq();
    load(32'hE1520003);
    ALUFlags = 4'b0100;
    tick(); tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd0,2'd0, 2'd0,2'd0,2'd1);
    if (obs !== exp_v) begin failures++; $display("FAIL cmp_execr got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd0,2'd0, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL cmp_aluwb got=%h exp=%h", obs, exp_v); end
    tick();
    ALUFlags = 4'b0000;
    load(32'h0A000002);
    checks++;
    if (obs !== E_FETCH) begin failures++; $display("FAIL beq_fetch got=%h exp=%h", obs, E_FETCH); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,1,2'd2,2'd2, 2'd1,2'd2,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL beq_decode got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(1,0,0,0, 0,0,2'd1,2'd2, 2'd1,2'd2,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL beq_taken got=%h exp=%h", obs, exp_v); end
    tick();
  endtask

  task automatic test_beq_not_taken();
    load(32'hE2921005);  // ADDS clears flags to 0000
    ALUFlags = 4'b0000;
    tick(); tick(); tick(); tick();
    load(32'h0A000002);
    tick(); tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd1,2'd2, 2'd1,2'd2,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL beq_nt_branch got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    if (obs !== E_FETCH) begin failures++; $display("FAIL beq_nt_return got=%h exp=%h", obs, E_FETCH); end
  endtask

  task automatic test_ldr_str();
    load(32'hE5921004);
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,1,2'd2,2'd2, 2'd0,2'd1,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL ldr_decode got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd1,2'd0, 2'd0,2'd1,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL ldr_memadr got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 1,0,2'd0,2'd0, 2'd0,2'd1,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL ldr_memrd got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,1,0,0, 0,0,2'd0,2'd1, 2'd0,2'd1,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL ldr_memwb got=%h exp=%h", obs, exp_v); end
    tick();
    load(32'hE5821004);
    checks++;
    if (obs !== E_FETCH) begin failures++; $display("FAIL str_fetch got=%h exp=%h", obs, E_FETCH); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,1,2'd2,2'd2, 2'd2,2'd1,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL str_decode got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd1,2'd0, 2'd2,2'd1,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL str_memadr got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(0,0,0,1, 1,0,2'd0,2'd0, 2'd2,2'd1,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL str_memwr got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    if (obs !== E_FETCH) begin failures++; $display("FAIL str_return got=%h exp=%h", obs, E_FETCH); end
  endtask

  task automatic test_reset_mid();
    load(32'hE1520003);  // CMP with all flags set -> 1111
    ALUFlags = 4'b1111;
    tick(); tick(); tick(); tick();
    ALUFlags = 4'b0000;
    load(32'hE5921004);
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    exp_v = mk(0,0,0,0, 0,1,2'd2,2'd2, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL reset_abort got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    load(32'h1A000002);  // BNE: taken only if Z was cleared
    checks++;
    if (obs !== E_FETCH) begin failures++; $display("FAIL reset_restart got=%h exp=%h", obs, E_FETCH); end
    tick(); tick();
    checks++;
    exp_v = mk(1,0,0,0, 0,0,2'd1,2'd2, 2'd1,2'd2,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL reset_flags_z got=%h exp=%h", obs, exp_v); end
    tick();
    load(32'h2A000002);  // BCS: C must also be 0
    tick(); tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd1,2'd2, 2'd1,2'd2,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL reset_flags_c got=%h exp=%h", obs, exp_v); end
    tick();
  endtask

  task automatic test_pc_write();
    load(32'hE08FF000);
    tick(); tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd0,2'd0, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL addpc_execr got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    exp_v = mk(1,0,0,0, 0,0,2'd0,2'd0, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL addpc_aluwb got=%h exp=%h", obs, exp_v); end
    tick();
  endtask

  task automatic test_cond_never_undef();
    load(32'hF2821005);
    tick(); tick(); tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,0,2'd0,2'd0, 2'd0,2'd0,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL nv_aluwb got=%h exp=%h", obs, exp_v); end
    tick();
    load(32'hEC000000);
    tick();
    checks++;
    exp_v = mk(0,0,0,0, 0,1,2'd2,2'd2, 2'd0,2'd3,2'd0);
    if (obs !== exp_v) begin failures++; $display("FAIL undef_decode got=%h exp=%h", obs, exp_v); end
    tick();
    checks++;
    if (obs !== E_FETCH) begin failures++; $display("FAIL undef_return got=%h exp=%h", obs, E_FETCH); end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_cmp_beq();
    test_beq_not_taken();
    test_ldr_str();
    test_reset_mid();
    test_pc_write();
    test_cond_never_undef();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
